// File: rtl/top16_frame_ctrl.sv
// Frame sequencer for the top-16 max/sum sorter: clears it, streams one frame of
// samples into it, waits for the sum to settle and hands {max, sum, count} downstream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start with a non-zero cfg_len
// CLEAR   | one cycle of sort_clr to wipe the previous frame
// FEED    | accepting samples until len have been taken
// DRAIN   | letting the sorter registers and sum register settle
// HOLD    | result presented, waiting for the consumer handshake
module top16_frame_ctrl #(
    parameter int W         = 12,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             synrst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [W-1:0]     s_data,
    output logic             s_ready,
    output logic             sort_clr,
    output logic             sort_en,
    output logic [W-1:0]     sort_data,
    input  logic [W-1:0]     sort_max,
    input  logic [W+3:0]     sort_sum,
    output logic             m_valid,
    output logic [W-1:0]     m_max,
    output logic [W+3:0]     m_sum,
    output logic [CNT_W-1:0] m_count,
    input  logic             m_ready,
    output logic             busy
);

    // The drain timer counts down from DRAIN_CYC-1 to zero, so it only needs
    // enough bits to hold DRAIN_CYC-1.
    localparam int DRN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   len_q,     len_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [DRN_W-1:0]   drn_q,     drn_d;
    logic               m_valid_q, m_valid_d;
    logic [W-1:0]       m_max_q,   m_max_d;
    logic [W+3:0]       m_sum_q,   m_sum_d;
    logic [CNT_W-1:0]   m_count_q, m_count_d;

    logic               accept;

    always_ff @(posedge clk) begin
        if (synrst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            drn_q     <= '0;
            m_valid_q <= 1'b0;
            m_max_q   <= '0;
            m_sum_q   <= '0;
            m_count_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            drn_q     <= drn_d;
            m_valid_q <= m_valid_d;
            m_max_q   <= m_max_d;
            m_sum_q   <= m_sum_d;
            m_count_q <= m_count_d;
        end
    end

    // abort wins over acceptance, so ready is withdrawn in the same cycle.
    always_comb begin
        s_ready = (state_q == ST_FEED) && !abort && !synrst;
        accept  = s_ready && s_valid;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        drn_d     = drn_q;
        m_valid_d = m_valid_q;
        m_max_d   = m_max_q;
        m_sum_d   = m_sum_q;
        m_count_d = m_count_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (cfg_len != '0)) begin
                        state_d = ST_CLEAR;
                        len_d   = cfg_len;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_FEED;
                end
                ST_FEED: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == (len_q - CNT_W'(1))) begin
                            state_d = ST_DRAIN;
                            drn_d   = DRN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drn_q == '0) begin
                        state_d   = ST_HOLD;
                        m_max_d   = sort_max;
                        m_sum_d   = sort_sum;
                        m_count_d = len_q;
                        m_valid_d = 1'b1;
                    end else begin
                        drn_d = drn_q - DRN_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        state_d   = ST_IDLE;
                        m_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sort_clr  = synrst || (state_q == ST_CLEAR);
        sort_en   = accept;
        sort_data = s_data;
        busy      = (state_q != ST_IDLE);
        m_valid   = m_valid_q;
        m_max     = m_max_q;
        m_sum     = m_sum_q;
        m_count   = m_count_q;
    end

endmodule

// File: tb/tb_top16_frame_ctrl.sv
// Directed bench for top16_frame_ctrl with a behavioural top-16 sorter model attached.
module tb_top16_frame_ctrl;

    logic        clk = 1'b0;
    logic        synrst;
    logic        start;
    logic [15:0] cfg_len;
    logic        abort;
    logic        s_valid;
    logic [11:0] s_data;
    logic        s_ready;
    logic        sort_clr;
    logic        sort_en;
    logic [11:0] sort_data;
    logic [11:0] sort_max;
    logic [15:0] sort_sum;
    logic        m_valid;
    logic [11:0] m_max;
    logic [15:0] m_sum;
    logic [15:0] m_count;
    logic        m_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int samples [32];

    always #5 clk = ~clk;

    top16_frame_ctrl #(.W(12), .CNT_W(16), .DRAIN_CYC(2)) dut (
        .clk       (clk),
        .synrst    (synrst),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .sort_clr  (sort_clr),
        .sort_en   (sort_en),
        .sort_data (sort_data),
        .sort_max  (sort_max),
        .sort_sum  (sort_sum),
        .m_valid   (m_valid),
        .m_max     (m_max),
        .m_sum     (m_sum),
        .m_count   (m_count),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    // Sorter model: max register updates with the sample, sum register one cycle later.
    logic [11:0] top_q [16];
    logic [11:0] max_q;
    logic [15:0] sum_q;
    logic [15:0] sum_c;
    int          min_idx;

    always_comb begin
        sum_c   = '0;
        min_idx = 0;
        for (int i = 0; i < 16; i++) begin
            sum_c = sum_c + 16'(top_q[i]);
            if (top_q[i] < top_q[min_idx]) min_idx = i;
        end
    end

    always @(posedge clk) begin
        if (sort_clr) begin
            for (int i = 0; i < 16; i++) top_q[i] <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else begin
            sum_q <= sum_c;
            if (sort_en) begin
                if (sort_data > top_q[min_idx]) top_q[min_idx] <= sort_data;
                if (sort_data > max_q) max_q <= sort_data;
            end
        end
    end

    assign sort_max = max_q;
    assign sort_sum = sum_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = 16'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Returns at the negedge following the last accepted sample.
    task automatic feed(input string tag, input int n, input int gap);
        int   idx   = 0;
        int   gcnt  = 0;
        int   guard = 0;
        logic acc;
        while (idx < n && guard < 1000) begin
            if (gcnt == 0) begin
                s_valid = 1'b1;
                s_data  = 12'(samples[idx]);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            acc = s_valid & s_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                gcnt = gap;
            end else if (gcnt > 0) begin
                gcnt--;
            end
        end
        s_valid = 1'b0;
        check({tag, "_fed"}, 32'(idx), 32'(n));
    endtask

    task automatic wait_result(input string tag, input int e_max, input int e_sum, input int e_cnt);
        int lat = 0;
        while (!m_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_drain_lat"}, 32'(lat), 32'd2);
        check({tag, "_max"},   32'(m_max),   32'(e_max));
        check({tag, "_sum"},   32'(m_sum),   32'(e_sum));
        check({tag, "_count"}, 32'(m_count), 32'(e_cnt));
    endtask

    task automatic handshake(input string tag);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_mvalid_off"}, 32'(m_valid), 32'd0);
        check({tag, "_idle"},       32'(busy),    32'd0);
    endtask

    initial begin
        synrst  = 1'b1;
        start   = 1'b0;
        cfg_len = '0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sort_clr", 32'(sort_clr), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        synrst = 1'b0;
        @(negedge clk);
        check("rst_s_ready",  32'(s_ready),  32'd0);
        check("rst_m_valid",  32'(m_valid),  32'd0);
        check("rst_m_count",  32'(m_count),  32'd0);
        check("rst_clr_off",  32'(sort_clr), 32'd0);

        // 1: 20 samples back-to-back
        for (int i = 0; i < 20; i++) samples[i] = i + 1;
        start_frame(20);
        feed("t1", 20, 0);
        wait_result("t1", 20, 200, 20);
        handshake("t1");

        // 2: gapped short frame, ready low in CLEAR and DRAIN
        samples[0] = 7; samples[1] = 3; samples[2] = 9;
        start_frame(3);
        check("t2_clear_rdy", 32'(s_ready),  32'd0);
        check("t2_clear_clr", 32'(sort_clr), 32'd1);
        feed("t2", 3, 2);
        check("t2_drain_rdy",  32'(s_ready), 32'd0);
        check("t2_drain_busy", 32'(busy),    32'd1);
        wait_result("t2", 9, 19, 3);
        handshake("t2");

        // 3: full-scale samples, sum at its ceiling
        for (int i = 0; i < 16; i++) samples[i] = 4095;
        start_frame(16);
        feed("t3", 16, 0);
        wait_result("t3", 4095, 65520, 16);
        handshake("t3");

        // 4: consumer stalls; start during HOLD must be ignored
        samples[0] = 10; samples[1] = 20; samples[2] = 30;
        start_frame(3);
        feed("t4", 3, 0);
        wait_result("t4", 30, 60, 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start   = 1'b1;
                cfg_len = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("t4_hold_valid", 32'(m_valid), 32'd1);
        check("t4_hold_max",   32'(m_max),   32'd30);
        check("t4_hold_sum",   32'(m_sum),   32'd60);
        check("t4_hold_busy",  32'(busy),    32'd1);
        handshake("t4");
        @(negedge clk);
        check("t4_no_queue", 32'(busy), 32'd0);

        // 5: abort mid-frame, then a clean short frame
        for (int i = 0; i < 10; i++) samples[i] = 500 + i;
        start_frame(10);
        feed("t5a", 5, 0);
        abort = 1'b1;
        #1;
        check("t5_abort_rdy", 32'(s_ready), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t5_no_result", 32'(m_valid), 32'd0);
        samples[0] = 2; samples[1] = 1;
        start_frame(2);
        feed("t5b", 2, 0);
        wait_result("t5", 2, 3, 2);
        handshake("t5");

        // 6: zero-length start ignored, then synrst mid-FEED
        start_frame(0);
        check("t6_len0_idle", 32'(busy),     32'd0);
        check("t6_len0_clr",  32'(sort_clr), 32'd0);
        for (int i = 0; i < 10; i++) samples[i] = 100 + i;
        start_frame(10);
        feed("t6", 3, 0);
        synrst = 1'b1;
        #1;
        check("t6_rst_clr", 32'(sort_clr), 32'd1);
        check("t6_rst_rdy", 32'(s_ready),  32'd0);
        @(negedge clk);
        synrst = 1'b0;
        check("t6_rst_idle",  32'(busy),    32'd0);
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_max",   32'(m_max),   32'd0);
        check("t6_rst_sum",   32'(m_sum),   32'd0);
        check("t6_rst_count", 32'(m_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
